// File: rtl/fp16_pkg.sv
// Shared types and helpers for the FP16 add/sub alignment front end.
//   EXP_W / FRAC_W / MANT_W : field widths (mantissa = {hidden, frac, G, R, S})
//   EXP_ALL_ONES            : Inf/NaN exponent encoding
//   state_e                 : sequencer FSM states
//   decode_exp()            : returns {hidden, effective exponent}
package fp16_pkg;

  localparam int unsigned EXP_W  = 5;
  localparam int unsigned FRAC_W = 10;
  localparam int unsigned MANT_W = 14;

  localparam logic [EXP_W-1:0] EXP_ALL_ONES = 5'h1F;

  typedef enum logic [1:0] {
    StIdle,
    StSub,
    StShift,
    StDone
  } state_e;

  // Denormals (exp == 0) have no hidden bit and behave as exponent 1.
  function automatic logic [EXP_W:0] decode_exp(input logic [EXP_W-1:0] e);
    logic hidden;
    hidden = (e != '0);
    return {hidden, hidden ? e : EXP_W'(1)};
  endfunction

endpackage

// File: rtl/fp16_exp_diff.sv
// Exponent comparator for the FP16 alignment front end (combinational).
//   ea, eb : effective exponents of operand A and B
//   diff   : 6-bit two's-complement ea - eb
//   swap   : 1 when eb > ea (diff negative); equal exponents never swap
//   mag    : |ea - eb|
module fp16_exp_diff
  import fp16_pkg::*;
(
  input  logic [EXP_W-1:0] ea,
  input  logic [EXP_W-1:0] eb,
  output logic [EXP_W:0]   diff,
  output logic             swap,
  output logic [EXP_W-1:0] mag
);

  logic [EXP_W:0] op_a;
  logic [EXP_W:0] op_b;
  logic [EXP_W:0] carry;

  // Ripple add of ea with the inverted eb and a carry-in of 1.
  always_comb begin
    op_a     = {1'b0, ea};
    op_b     = ~{1'b0, eb};
    carry    = '0;
    diff     = '0;
    carry[0] = 1'b1;
    for (int i = 0; i < EXP_W; i++) begin
      diff[i]    = op_a[i] ^ op_b[i] ^ carry[i];
      carry[i+1] = (op_a[i] & op_b[i]) | (carry[i] & (op_a[i] ^ op_b[i]));
    end
    diff[EXP_W] = op_a[EXP_W] ^ op_b[EXP_W] ^ carry[EXP_W];
  end

  assign swap = diff[EXP_W];
  // Range is -30..+30, so the negated low bits always fit.
  assign mag  = swap ? (~diff[EXP_W-1:0] + 1'b1) : diff[EXP_W-1:0];

endmodule

// File: rtl/fp16_align_sequencer.sv
// Multi-cycle FP16 add/sub front end: accepts A, B, op; orders operands by
// exponent; right-shifts the smaller mantissa one bit per clock with sticky.
//   clk, rst             : clock, async active-high reset
//   in_valid / in_ready  : operand handshake (a, b, op)
//   out_valid / out_ready: result handshake
//   exp_l                : common (larger) exponent
//   mant_l / mant_s      : larger / aligned smaller mantissa {hidden, frac, G, R, S}
//   sign_l, eff_sub      : sign of larger operand after op, effective subtraction
//   swapped, special     : B was larger, either operand Inf/NaN
module fp16_align_sequencer
  import fp16_pkg::*;
#(
  parameter int unsigned MAX_SHIFT = MANT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       a,
  input  logic [15:0]       b,
  input  logic              op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  exp_l,
  output logic [MANT_W-1:0] mant_l,
  output logic [MANT_W-1:0] mant_s,
  output logic              sign_l,
  output logic              eff_sub,
  output logic              swapped,
  output logic              special
);

  state_e              state_q, state_d;
  logic [15:0]         a_q, a_d, b_q, b_d;
  logic                op_q, op_d;
  logic [EXP_W-1:0]    exp_l_q, exp_l_d;
  logic [MANT_W-1:0]   mant_l_q, mant_l_d, mant_s_q, mant_s_d;
  logic                sign_l_q, sign_l_d, eff_sub_q, eff_sub_d;
  logic                swapped_q, swapped_d, special_q, special_d;
  logic [3:0]          cnt_q, cnt_d;

  logic [EXP_W:0]      dec_a, dec_b, diff;
  logic [MANT_W-1:0]   mant_a, mant_b;
  logic                swap, spec_in;
  logic [EXP_W-1:0]    mag;
  logic [3:0]          cnt_sat;

  assign dec_a   = decode_exp(a_q[14:10]);
  assign dec_b   = decode_exp(b_q[14:10]);
  assign mant_a  = {dec_a[EXP_W], a_q[FRAC_W-1:0], 3'b000};
  assign mant_b  = {dec_b[EXP_W], b_q[FRAC_W-1:0], 3'b000};
  assign spec_in = (a_q[14:10] == EXP_ALL_ONES) || (b_q[14:10] == EXP_ALL_ONES);

  fp16_exp_diff u_exp_diff (
    .ea   (dec_a[EXP_W-1:0]),
    .eb   (dec_b[EXP_W-1:0]),
    .diff (diff),
    .swap (swap),
    .mag  (mag)
  );

  // Beyond MAX_SHIFT the smaller operand has collapsed into the sticky bit.
  assign cnt_sat = (mag > EXP_W'(MAX_SHIFT)) ? 4'(MAX_SHIFT) : mag[3:0];

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    exp_l_d   = exp_l_q;
    mant_l_d  = mant_l_q;
    mant_s_d  = mant_s_q;
    sign_l_d  = sign_l_q;
    eff_sub_d = eff_sub_q;
    swapped_d = swapped_q;
    special_d = special_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          state_d = StSub;
        end
      end
      StSub: begin
        exp_l_d   = swap ? dec_b[EXP_W-1:0] : dec_a[EXP_W-1:0];
        mant_l_d  = swap ? mant_b : mant_a;
        mant_s_d  = swap ? mant_a : mant_b;
        sign_l_d  = swap ? (b_q[15] ^ op_q) : a_q[15];
        eff_sub_d = a_q[15] ^ b_q[15] ^ op_q;
        swapped_d = swap;
        special_d = spec_in;
        if (spec_in || (diff == '0)) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d   = cnt_sat;
          state_d = StShift;
        end
      end
      StShift: begin
        mant_s_d = {1'b0, mant_s_q[MANT_W-1:2], |mant_s_q[1:0]};
        cnt_d    = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 1'b0;
      exp_l_q   <= '0;
      mant_l_q  <= '0;
      mant_s_q  <= '0;
      sign_l_q  <= 1'b0;
      eff_sub_q <= 1'b0;
      swapped_q <= 1'b0;
      special_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      exp_l_q   <= exp_l_d;
      mant_l_q  <= mant_l_d;
      mant_s_q  <= mant_s_d;
      sign_l_q  <= sign_l_d;
      eff_sub_q <= eff_sub_d;
      swapped_q <= swapped_d;
      special_q <= special_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign exp_l     = exp_l_q;
  assign mant_l    = mant_l_q;
  assign mant_s    = mant_s_q;
  assign sign_l    = sign_l_q;
  assign eff_sub   = eff_sub_q;
  assign swapped   = swapped_q;
  assign special   = special_q;

endmodule

// File: tb/tb_fp16_align_sequencer.sv
module tb_fp16_align_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  exp_l;
  logic [13:0] mant_l;
  logic [13:0] mant_s;
  logic        sign_l;
  logic        eff_sub;
  logic        swapped;
  logic        special;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp16_align_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .exp_l     (exp_l),
    .mant_l    (mant_l),
    .mant_s    (mant_s),
    .sign_l    (sign_l),
    .eff_sub   (eff_sub),
    .swapped   (swapped),
    .special   (special)
  );

  typedef struct {
    logic [4:0]  exp_l;
    logic [13:0] mant_l;
    logic [13:0] mant_s;
    logic        sign_l;
    logic        eff_sub;
    logic        swapped;
    logic        special;
    int          lat;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference: plain integer arithmetic on the FP16 fields.
  function automatic exp_t model(input logic [15:0] xa, input logic [15:0] xb, input logic xop);
    exp_t e;
    int   ea, eb, ma, mb, ms, d, n, res;
    ea = int'(xa[14:10]);
    eb = int'(xb[14:10]);
    ma = ((ea != 0) ? 1024 : 0) + int'(xa[9:0]);
    mb = ((eb != 0) ? 1024 : 0) + int'(xb[9:0]);
    ma = ma * 8;
    mb = mb * 8;
    e.special = (ea == 31) || (eb == 31);
    if (ea == 0) ea = 1;
    if (eb == 0) eb = 1;
    d = ea - eb;
    e.eff_sub = xa[15] ^ xb[15] ^ xop;
    if (d < 0) begin
      e.swapped = 1'b1;
      e.exp_l   = 5'(eb);
      e.mant_l  = 14'(mb);
      ms        = ma;
      e.sign_l  = xb[15] ^ xop;
      n         = -d;
    end else begin
      e.swapped = 1'b0;
      e.exp_l   = 5'(ea);
      e.mant_l  = 14'(ma);
      ms        = mb;
      e.sign_l  = xa[15];
      n         = d;
    end
    if (n > 14) n = 14;
    if (e.special) n = 0;
    res = ms >> n;
    if ((ms & ((1 << n) - 1)) != 0) res = res | 1;
    e.mant_s = 14'(res);
    e.lat    = 1 + n;
    return e;
  endfunction

  // Called at #1 after an edge with the DUT idle; returns at #1 after the accept edge.
  task automatic start_op(input logic [15:0] xa, input logic [15:0] xb, input logic xop,
                          input string tag);
    a        = xa;
    b        = xb;
    op       = xop;
    in_valid = 1'b1;
    check({tag, ".in_ready_idle"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [15:0] xa, input logic [15:0] xb, input logic xop,
                        input string tag, input int hold);
    exp_t e;
    int   lat;
    e = model(xa, xb, xop);
    start_op(xa, xb, xop, tag);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".latency"}, lat, e.lat);
    check({tag, ".swapped"}, swapped, e.swapped);
    check({tag, ".exp_l"}, exp_l, e.exp_l);
    check({tag, ".mant_l"}, mant_l, e.mant_l);
    check({tag, ".mant_s"}, mant_s, e.mant_s);
    check({tag, ".sign_l"}, sign_l, e.sign_l);
    check({tag, ".eff_sub"}, eff_sub, e.eff_sub);
    check({tag, ".special"}, special, e.special);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a        = 16'($urandom);
      b        = 16'($urandom);
      @(posedge clk);
      #1;
      check({tag, ".hold_valid"}, out_valid, 1);
      check({tag, ".hold_in_ready"}, in_ready, 0);
      check({tag, ".hold_mant_s"}, mant_s, e.mant_s);
      check({tag, ".hold_exp_l"}, exp_l, e.exp_l);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".idle_in_ready"}, in_ready, 1);
    check({tag, ".idle_out_valid"}, out_valid, 0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    op        = 1'b0;
    #1;
    check("rst.in_ready", in_ready, 1);
    check("rst.out_valid", out_valid, 0);
    check("rst.exp_l", exp_l, 0);
    check("rst.mant_l", mant_l, 0);
    check("rst.mant_s", mant_s, 0);
    check("rst.flags", {sign_l, eff_sub, swapped, special}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    run_op(16'h3C00, 16'h3800, 1'b0, "s1", 0);
    run_op(16'h3800, 16'h3C00, 1'b1, "s2", 0);
    run_op(16'h7800, 16'h3C01, 1'b0, "s3_sat", 0);
    run_op(16'h7C00, 16'h3C00, 1'b0, "s3_special", 0);
    run_op(16'h3E00, 16'hBC00, 1'b0, "s4_equal", 0);
    run_op(16'h0001, 16'h0400, 1'b1, "denorm", 0);
    // Backpressure, then an immediate follow-on accept.
    run_op(16'h3C00, 16'h3800, 1'b0, "s5_hold", 5);
    run_op(16'hC000, 16'h3555, 1'b1, "s5_next", 0);

    // Reset in the middle of a long shift.
    start_op(16'h7800, 16'h3C01, 1'b0, "s6");
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("s6.rst_out_valid", out_valid, 0);
    check("s6.rst_in_ready", in_ready, 1);
    check("s6.rst_mant_s", mant_s, 0);
    check("s6.rst_exp_l", exp_l, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(16'h3C00, 16'h3800, 1'b0, "s6_after", 0);

    for (int k = 0; k < 40; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 1) == 1) rb[14:10] = ra[14:10] ^ 5'($urandom_range(0, 3));
      run_op(ra, rb, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", k),
             int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
